// File: rtl/cv32e40p_x_if_pkg.sv
// cv32e40p_x_if_pkg: shared types for the X-interface result path
package cv32e40p_x_if_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } x_result_t;
endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// cv32e40p_x_result_fifo: in-order FIFO of accelerator results, DEPTH a power of two
module cv32e40p_x_result_fifo
  import cv32e40p_x_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  x_result_t                data_i,
  input  logic                     pop_i,
  output x_result_t                data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  x_result_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full_o  = count_o == CW'(DEPTH);
  assign empty_o = count_o == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(do_push);
      rd_ptr  <= rd_ptr + AW'(do_pop);
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; count gates every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/cv32e40p_x_result_buf.sv
// cv32e40p_x_result_buf: buffers X-interface results and writes them back through free WB port cycles
// Optional: CV32E40P_X_RESULT_BYPASS_EN retires a result arriving at an empty buffer in the same cycle.
module cv32e40p_x_result_buf
  import cv32e40p_x_if_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        x_rvalid_i,
  output logic        x_rready_o,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_data_i,
  input  logic        x_we_i,
  input  logic        regfile_core_we_i,
  output logic        regfile_x_we_o,
  output logic [4:0]  regfile_x_waddr_o,
  output logic [31:0] regfile_x_wdata_o,
  output logic        x_rvalid_o,
  output logic [4:0]  x_rwaddr_o,
  output logic        x_wb_prio_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  x_result_t     in_res, head, sel;
  logic          full, empty, push, pop, byp, ret;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_q;
  assign in_res = '{rd: x_rd_i, data: x_data_i, we: x_we_i};
`ifdef CV32E40P_X_RESULT_BYPASS_EN
  assign byp = empty & x_rvalid_i & ~regfile_core_we_i;
`else
  assign byp = 1'b0;
`endif
  assign x_rready_o = count != CW'(DEPTH);
  assign push       = x_rvalid_i & ~full & ~byp;
  assign pop        = ~empty & ~regfile_core_we_i;
  assign ret        = pop | byp;
  assign sel        = byp ? in_res : head;
  cv32e40p_x_result_fifo #(.DEPTH(DEPTH)) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (in_res),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // count consecutive cycles the core blocks a valid head, saturating at the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else if (empty | pop) starve_q <= '0;
    else if (starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
  end
  // retire strobe and register-file write for the selected result
  always_comb begin
    x_rvalid_o        = ret;
    x_rwaddr_o        = ret ? sel.rd : '0;
    regfile_x_we_o    = ret & sel.we & (sel.rd != '0);
    regfile_x_waddr_o = regfile_x_we_o ? sel.rd : '0;
    regfile_x_wdata_o = regfile_x_we_o ? sel.data : '0;
    x_wb_prio_o       = (starve_q == SW'(STARVE_LIMIT)) & ~empty;
  end
endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// tb_cv32e40p_x_result_buf: random and directed checks against a queue model
module tb_cv32e40p_x_result_buf;
  import cv32e40p_x_if_pkg::*;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;
  logic clk_i = 0, rst_ni = 0;
  logic x_rvalid_i = 0, x_we_i = 0, regfile_core_we_i = 0;
  logic [4:0] x_rd_i = 0;
  logic [31:0] x_data_i = 0;
  logic x_rready_o, regfile_x_we_o, x_rvalid_o, x_wb_prio_o;
  logic [4:0] regfile_x_waddr_o, x_rwaddr_o;
  logic [31:0] regfile_x_wdata_o;
  int total = 0, bad = 0;
  x_result_t q[$];
  int starve = 0;
  logic s_ready, s_we, s_rv, s_prio;
  logic [4:0] s_waddr, s_rwa;
  logic [31:0] s_wdata;

  cv32e40p_x_result_buf #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .x_rvalid_i(x_rvalid_i), .x_rready_o(x_rready_o),
    .x_rd_i(x_rd_i), .x_data_i(x_data_i), .x_we_i(x_we_i),
    .regfile_core_we_i(regfile_core_we_i), .regfile_x_we_o(regfile_x_we_o),
    .regfile_x_waddr_o(regfile_x_waddr_o), .regfile_x_wdata_o(regfile_x_wdata_o),
    .x_rvalid_o(x_rvalid_o), .x_rwaddr_o(x_rwaddr_o), .x_wb_prio_o(x_wb_prio_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // one clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic we, input logic cwe);
    x_result_t e;
    logic byp, ret, rdy, wexp;
    @(negedge clk_i);
    x_rvalid_i = v; x_rd_i = rd; x_data_i = d; x_we_i = we; regfile_core_we_i = cwe;
    #1;
    rdy = q.size() != DEPTH;
`ifdef CV32E40P_X_RESULT_BYPASS_EN
    byp = q.size() == 0 && v && !cwe;
`else
    byp = 0;
`endif
    ret = byp || (q.size() > 0 && !cwe);
    e = byp ? '{rd: rd, data: d, we: we} : (q.size() > 0 ? q[0] : '0);
    wexp = ret && e.we && e.rd != 0;
    s_ready = x_rready_o; s_we = regfile_x_we_o; s_waddr = regfile_x_waddr_o;
    s_wdata = regfile_x_wdata_o; s_rv = x_rvalid_o; s_rwa = x_rwaddr_o; s_prio = x_wb_prio_o;
    cmp("rready", 32'(s_ready), 32'(rdy));
    cmp("rvalid_o", 32'(s_rv), 32'(ret));
    cmp("rwaddr", 32'(s_rwa), ret ? 32'(e.rd) : 0);
    cmp("x_we", 32'(s_we), 32'(wexp));
    cmp("waddr", 32'(s_waddr), wexp ? 32'(e.rd) : 0);
    cmp("wdata", s_wdata, wexp ? e.data : 0);
    cmp("prio", 32'(s_prio), 32'(starve == LIM && q.size() > 0));
    if (q.size() == 0 || (ret && !byp)) starve = 0;
    else if (cwe && starve < LIM) starve++;
    if (ret && !byp) void'(q.pop_front());
    if (v && rdy && !byp) q.push_back('{rd: rd, data: d, we: we});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0; x_rvalid_i = 0; regfile_core_we_i = 0; x_we_i = 0; x_rd_i = 0; x_data_i = 0;
    #1;
    cmp("rst_rready", 32'(x_rready_o), 1);
    cmp("rst_rvalid", 32'(x_rvalid_o), 0);
    cmp("rst_we", 32'(regfile_x_we_o), 0);
    cmp("rst_prio", 32'(x_wb_prio_o), 0);
    cmp("rst_rwaddr", 32'(x_rwaddr_o), 0);
    q.delete();
    starve = 0;
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    do_reset();
`ifndef CV32E40P_X_RESULT_BYPASS_EN
    step(1, 5, 32'hDEADBEEF, 1, 0);
    cmp("t1_lat", 32'(s_rv), 0);
    step(0, 0, 0, 0, 0);
    cmp("t1_we", 32'(s_we), 1);
    cmp("t1_waddr", 32'(s_waddr), 5);
    cmp("t1_wdata", s_wdata, 32'hDEADBEEF);
    cmp("t1_rwaddr", 32'(s_rwa), 5);
    step(1, 1, 32'hA, 1, 1);
    step(1, 2, 32'hB, 1, 1);
    step(1, 3, 32'hC, 1, 1);
    cmp("t2_full", 32'(s_ready), 0);
    step(1, 3, 32'hC, 1, 0);
    cmp("t2_pop1", 32'(s_rwa), 1);
    step(1, 3, 32'hC, 1, 0);
    cmp("t2_pop2", 32'(s_rwa), 2);
    step(0, 0, 0, 0, 0);
    cmp("t2_pop3", 32'(s_rwa), 3);
    step(1, 0, 32'h11, 1, 0);
    step(1, 7, 32'h22, 0, 0);
    cmp("t3_rd0_rv", 32'(s_rv), 1);
    cmp("t3_rd0_we", 32'(s_we), 0);
    step(0, 0, 0, 0, 0);
    cmp("t3_rd7_rwa", 32'(s_rwa), 7);
    cmp("t3_rd7_we", 32'(s_we), 0);
    step(1, 9, 32'h99, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    cmp("t4_prio_early", 32'(s_prio), 0);
    step(0, 0, 0, 0, 1);
    cmp("t4_prio", 32'(s_prio), 1);
    step(0, 0, 0, 0, 0);
    cmp("t4_pop", 32'(s_rwa), 9);
    step(0, 0, 0, 0, 0);
    cmp("t4_prio_clr", 32'(s_prio), 0);
    step(1, 1, 32'h1, 1, 1);
    step(1, 2, 32'h2, 1, 1);
    step(1, 3, 32'h3, 1, 0);
    cmp("t5_rdy0", 32'(s_ready), 0);
    step(0, 0, 0, 0, 0);
    cmp("t5_rdy1", 32'(s_ready), 1);
    cmp("t5_head", 32'(s_rwa), 2);
    step(0, 0, 0, 0, 0);
    cmp("t5_cnt1", 32'(s_rv), 0);
    step(1, 4, 32'h4, 1, 1);
    step(1, 6, 32'h6, 1, 1);
    do_reset();
    step(0, 0, 0, 0, 0);
    cmp("t6_rv", 32'(s_rv), 0);
    cmp("t6_rdy", 32'(s_ready), 1);
`else
    step(1, 3, 32'h1234, 1, 0);
    cmp("byp_we", 32'(s_we), 1);
    cmp("byp_waddr", 32'(s_waddr), 3);
    cmp("byp_wdata", s_wdata, 32'h1234);
`endif
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom, 1'($urandom),
           1'($urandom_range(0, 2) != 0));
    do_reset();
    for (int i = 0; i < 100; i++)
      step(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
